// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_t          : FSM encoding (ST_IDLE, ST_SHIFT, ST_GAP, ST_DONE)
//   DEFAULT_PAT_1001 : built-in pattern sent when use_default=1
//   clog2()          : ceiling log2, never smaller than 1, for sizing counters
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DEFAULT_PAT_1001 = 4'b1001;

  // Returns at least 1 so a counter sized from it is never zero bits wide.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-in, serial-out shift register, MSB first.
// Ports:
//   clk, rst : clock and synchronous active-high reset (clears contents)
//   load     : copy din into the register (wins over shift)
//   shift    : shift left by one, zero filling the LSB
//   din      : parallel load data
//   sout     : current MSB, i.e. the bit being presented
module seq_piso_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign sout = q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured WIDTH-bit pattern MSB first,
// repeated repeat_cnt times (0 counts as 1) with GAP idle cycles between
// frames, then pulses done.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle request, accepted only while idle
//   use_default : 1 = send DEFAULT_PAT, 0 = send pattern
//   pattern     : pattern captured when start is accepted
//   repeat_cnt  : number of frames, captured when start is accepted
//   out         : serial data bit (0 when not valid)
//   out_valid   : out carries a pattern bit this cycle
//   busy        : burst in progress (frames and gaps)
//   done        : one-cycle pulse after the final bit
//   dbg_state   : internal FSM state, for checkers
//
// Stream semantics: there is no back-pressure. A bit is transferred on every
// cycle where out_valid=1; the consumer must take it then. start is a
// request without acknowledge: it is simply dropped unless the block is idle
// and not showing done.
//
// The outputs are registered from the FSM state, so they trail the state by
// one cycle: start accepted at edge N moves the FSM to SHIFT, and the first
// bit appears after edge N+1.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               GAP         = 0,
  parameter int               CNT_W       = 8,
  parameter logic [WIDTH-1:0] DEFAULT_PAT = WIDTH'(DEFAULT_PAT_1001)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_default,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  localparam int BW = clog2(WIDTH);
  localparam int GW = clog2(GAP + 1);

  state_t           state;
  logic [BW-1:0]    bit_idx;
  logic [CNT_W-1:0] frames_left;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] pat_q;

  logic             accept;
  logic             reload;
  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_din;
  logic             sh_msb;

  // done is still visible while the FSM is already back in IDLE; a start in
  // that cycle belongs to the finishing burst and is dropped.
  always_comb begin
    accept   = 1'b0;
    reload   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_din   = pat_q;
    accept   = (state == ST_IDLE) && start && !done;
    reload   = (state == ST_SHIFT) && (bit_idx == '0) && (frames_left > CNT_W'(1));
    sh_load  = accept || reload;
    sh_shift = (state == ST_SHIFT);
    if (accept) begin
      sh_din = use_default ? DEFAULT_PAT : pattern;
    end
  end

  seq_piso_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .sout  (sh_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_idx     <= '0;
      frames_left <= '0;
      gap_cnt     <= '0;
      pat_q       <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      out       <= (state == ST_SHIFT) && sh_msb;
      out_valid <= (state == ST_SHIFT);
      busy      <= (state == ST_SHIFT) || (state == ST_GAP);
      done      <= (state == ST_DONE);

      case (state)
        ST_IDLE: begin
          if (accept) begin
            pat_q       <= sh_din;
            frames_left <= (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
            bit_idx     <= BW'(WIDTH - 1);
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_idx == '0) begin
            if (frames_left > CNT_W'(1)) begin
              // The shift register reloads from pat_q this same cycle.
              frames_left <= frames_left - CNT_W'(1);
              bit_idx     <= BW'(WIDTH - 1);
              if (GAP == 0) begin
                state <= ST_SHIFT;
              end else begin
                gap_cnt <= GW'((GAP > 0) ? (GAP - 1) : 0);
                state   <= ST_GAP;
              end
            end else begin
              state <= ST_DONE;
            end
          end else begin
            bit_idx <= bit_idx - BW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_SHIFT;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
